// File: rtl/serial_add3_pkg.sv
// Shared definitions for the bit-serial three-operand adder.
//   state_t : controller states IDLE -> RUN -> DONE -> IDLE
//   CARRY_W : width of the carry between bit positions. Three operand bits
//             plus a carry of at most 3 can reach 6, so two bits are needed.
package serial_add3_pkg;

  localparam int CARRY_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_add3_seq_bit_cell.sv
// add3_bit_cell: combinational one-bit, three-operand adder slice.
// Ports:
//   a, b, c : operand bits
//   cin     : incoming 2-bit carry
//   s       : sum bit
//   cout    : outgoing 2-bit carry, where {cout, s} = a + b + c + cin
module add3_bit_cell
  import serial_add3_pkg::*;
(
  input  logic               a,
  input  logic               b,
  input  logic               c,
  input  logic [CARRY_W-1:0] cin,
  output logic               s,
  output logic [CARRY_W-1:0] cout
);

  logic [CARRY_W:0] total;

  assign total       = {2'b00, a} + {2'b00, b} + {2'b00, c} + {1'b0, cin};
  assign {cout, s}   = total;

endmodule

// File: rtl/serial_add3_seq.sv
// serial_add3_seq: adds three unsigned WIDTH-bit operands one bit per cycle,
// LSB first, through a single shared add3_bit_cell.
// Build option: define SERIAL_ADD3_ABORT_EN to add the abort input, which
// cancels an operation that is still in RUN.
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   in_valid   : operand triple offered
//   in_ready   : operands accepted this cycle (high only in IDLE)
//   a, b, c    : unsigned operands
//   out_valid  : result available (DONE)
//   out_ready  : consumer takes the result this cycle
//   sum        : a + b + c, WIDTH+2 bits, zero whenever out_valid is low
//   busy       : high in every state except IDLE
//   abort      : (SERIAL_ADD3_ABORT_EN only) cancel a run in progress
// Latency: an accept in cycle N gives out_valid in cycle N+WIDTH+1.
module serial_add3_seq
  import serial_add3_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH+1:0] sum,
`ifdef SERIAL_ADD3_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy
);

  localparam int                CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);

  state_t             state;
  logic [WIDTH-1:0]   a_sr;
  logic [WIDTH-1:0]   b_sr;
  logic [WIDTH-1:0]   c_sr;
  logic [CARRY_W-1:0] carry;
  logic [CNT_W-1:0]   cnt;
  // Result accumulates here LSB first; it is only visible on sum in DONE.
  logic [WIDTH+1:0]   acc;

  logic               cell_s;
  logic [CARRY_W-1:0] cell_cout;

  add3_bit_cell u_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .c    (c_sr[0]),
    .cin  (carry),
    .s    (cell_s),
    .cout (cell_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      carry     <= '0;
      cnt       <= '0;
      acc       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr     <= a;
            b_sr     <= b;
            c_sr     <= c;
            carry    <= '0;
            cnt      <= '0;
            acc      <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end

        RUN: begin
`ifdef SERIAL_ADD3_ABORT_EN
          if (abort) begin
            state    <= IDLE;
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end else
`endif
          begin
            a_sr               <= a_sr >> 1;
            b_sr               <= b_sr >> 1;
            c_sr               <= c_sr >> 1;
            carry              <= cell_cout;
            cnt                <= cnt + CNT_W'(1);
            acc[WIDTH-1:0]     <= {cell_s, acc[WIDTH-1:1]};
            // On the last bit the outgoing carry becomes the top two sum bits.
            if (cnt == LAST_BIT) begin
              acc[WIDTH+1:WIDTH] <= cell_cout;
              state              <= DONE;
              out_valid          <= 1'b1;
            end
          end
        end

        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            acc       <= '0;
          end
        end

        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // Partial results in acc during RUN must not leak onto sum.
  assign sum = out_valid ? acc : '0;

endmodule

// File: tb/tb_serial_add3_seq.sv
module tb_serial_add3_seq;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH+1:0] sum;
  logic             busy;
`ifdef SERIAL_ADD3_ABORT_EN
  logic             abort;
`endif

  int vectors     = 0;
  int miscompares = 0;

  serial_add3_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c         (c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
`ifdef SERIAL_ADD3_ABORT_EN
    .abort     (abort),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: result is plain integer a+b+c; result appears exactly WIDTH
  // edges after the accepting edge and holds until out_ready.
  task automatic do_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                       input logic [WIDTH-1:0] tc, input int stall, input bit intrude);
    int exp_sum;
    int n;
    exp_sum = int'(ta) + int'(tb) + int'(tc);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    a = ta; b = tb; c = tc;
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    tick();
    in_valid = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom); c = WIDTH'($urandom);
    check("busy_run", 32'(busy), 32'd1);
    check("in_ready_run", 32'(in_ready), 32'd0);
    check("sum_zero_run", 32'(sum), 32'd0);
    n = 0;
    while (!out_valid && n < 4 * WIDTH) begin
      in_valid = intrude && (n < 3);
      if (intrude) begin a = 1; b = 1; c = 1; end
      tick();
      n++;
    end
    in_valid = 1'b0;
    check("latency", 32'(n), 32'(WIDTH));
    check("sum", 32'(sum), 32'(exp_sum));
    for (int i = 0; i < stall; i++) begin
      tick();
      check("held_valid", 32'(out_valid), 32'd1);
      check("held_sum", 32'(sum), 32'(exp_sum));
    end
    out_ready = 1'b1;
    tick();
    check("ret_valid", 32'(out_valid), 32'd0);
    check("ret_ready", 32'(in_ready), 32'd1);
    check("ret_busy", 32'(busy), 32'd0);
    check("ret_sum", 32'(sum), 32'd0);
  endtask

  initial begin
    int seen;
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    a = 8'd5; b = 8'd6; c = 8'd7;
`ifdef SERIAL_ADD3_ABORT_EN
    abort = 1'b0;
`endif
    tick(); tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    rst = 1'b0; in_valid = 1'b0;

    do_op(8'd0, 8'd0, 8'd0, 0, 1'b0);
    do_op(8'd255, 8'd255, 8'd255, 0, 1'b0);
    do_op(8'd10, 8'd20, 8'd30, 5, 1'b0);
    do_op(8'd100, 8'd50, 8'd3, 0, 1'b1);

    // Reset in the middle of a run.
    a = 8'd200; b = 8'd100; c = 8'd50; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    seen = 0;
    for (int i = 0; i < WIDTH + 2; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check("mid_rst_no_valid", 32'(seen), 32'd0);
    do_op(8'd7, 8'd8, 8'd9, 0, 1'b0);

`ifdef SERIAL_ADD3_ABORT_EN
    a = 8'd40; b = 8'd41; c = 8'd42; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_ready", 32'(in_ready), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    seen = 0;
    for (int i = 0; i < WIDTH + 2; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check("abort_no_valid", 32'(seen), 32'd0);
`else
    do_op(8'd40, 8'd41, 8'd42, 0, 1'b0);
`endif

    for (int k = 0; k < 20; k++) begin
      do_op(WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom),
            int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_add3_seq.md
SERIAL_ADD3_SEQ -- requirements
Module: serial_add3_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  operand triple offered.
REQ-005 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-006 SHALL have ports a, b, c  input  WIDTH each  unsigned operands.
REQ-007 SHALL have port out_valid  output  1  result available.
REQ-008 SHALL have port out_ready  input  1  consumer takes the result this cycle.
REQ-009 SHALL have port sum  output  WIDTH+2  unsigned a+b+c.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-011 SHALL implement the FSM IDLE -> RUN -> DONE -> IDLE.
REQ-012 In IDLE, in_ready SHALL be 1; in every other state it SHALL be 0.
REQ-013 On in_valid&&in_ready, SHALL capture a, b and c into shift registers, clear the 2-bit carry and the bit counter, and enter RUN.
REQ-014 In RUN, each cycle SHALL add bit i of each operand plus the 2-bit carry in one shared bit-cell, shift the sum bit into the result register LSB-first, and update the carry.
REQ-015 After WIDTH RUN cycles, SHALL write carry[1:0] into sum[WIDTH+1:WIDTH] and enter DONE.
REQ-016 Latency SHALL be fixed: accept in cycle N gives out_valid=1 in cycle N+WIDTH+1, independent of operand values.
REQ-017 In DONE, out_valid SHALL be 1 and sum SHALL hold stable until out_ready=1; on that cycle the FSM SHALL return to IDLE.
REQ-018 in_valid in RUN or DONE SHALL be ignored, with no capture and no effect on the result.
REQ-019 The maximum result (3*(2^WIDTH-1)) SHALL be exact, with no wrap; for example, 765 for WIDTH=8.
REQ-020 sum SHALL be 0 whenever out_valid=0.

Reset
REQ-021 rst=1 at a clock edge SHALL force IDLE, in_ready=1, out_valid=0, busy=0, sum=0, and clear the carry and the counter.
REQ-022 rst SHALL take priority over every handshake.
REQ-023 rst asserted during RUN or DONE SHALL discard the operation and produce no out_valid.

Configuration
REQ-024 Macro SERIAL_ADD3_ABORT_EN SHALL control whether abort support is compiled in.
REQ-025 With SERIAL_ADD3_ABORT_EN defined, SHALL add port abort  input  1; abort=1 in RUN SHALL return the FSM to IDLE next cycle with out_valid staying 0.
REQ-026 With SERIAL_ADD3_ABORT_EN defined, abort SHALL be ignored in IDLE and DONE.
REQ-027 Without SERIAL_ADD3_ABORT_EN, the abort port and its logic SHALL be absent, and behaviour SHALL equal the defined case with abort=0.

Structure
REQ-028 Package serial_add3_pkg SHALL hold the FSM state typedef (IDLE, RUN, DONE) and the carry width constant (2).
REQ-029 The bit-cell SHALL be a combinational sub-module add3_bit_cell with inputs a, b, c and cin[1:0] and outputs s and cout[1:0], where {cout,s} = a+b+c+cin.
REQ-030 The counter SHALL be $clog2(WIDTH+1) bits wide.

Verification
REQ-031 Zero operands: a=b=c=0, accepted in cycle 0 -> out_valid in cycle 9, sum=0.
REQ-032 Maximum operands: a=b=c=255 -> sum=765 (0x2FD), out_valid in cycle 9.
REQ-033 Backpressure: a=10, b=20, c=30 with out_ready low for 5 cycles -> sum=60 held stable; return to IDLE the cycle after out_ready=1.
REQ-034 New operands during a run: in_valid with a=1, b=1, c=1 pulsed during RUN of a=100, b=50, c=3 -> sum=153, second triple not captured.
REQ-035 Reset mid-run: rst pulsed at RUN cycle 4 -> in_ready=1 and out_valid=0 next cycle; a following triple 7+8+9 -> sum=24.
REQ-036 Abort (SERIAL_ADD3_ABORT_EN defined): abort at RUN cycle 3 -> IDLE next cycle with no out_valid; without the macro, the same stimulus with abort removed completes normally.
